// File: rtl/synaptic_weight_accumulator.sv
// synaptic_weight_accumulator: per-neuron excitatory/inhibitory weight sums over a spike stream.
// Define SATURATING_ACCUM_EN to clamp each add at the signed limits instead of wrapping.
module synaptic_weight_accumulator #(
  parameter int INTEGER_WIDTH   = 32,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int SYN_ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [SYN_ADDR_WIDTH-1:0] WeightBase,
  input  logic                      SpikeValid,
  output logic                      SpikeReady,
  input  logic [SYN_ADDR_WIDTH-1:0] SpikePreIndex,
  input  logic                      SpikeExcitatory,
  input  logic                      SpikeLast,
  output logic                      WeightRdEn,
  output logic [SYN_ADDR_WIDTH-1:0] WeightRdAddr,
  input  logic [DATA_WIDTH-1:0]     WeightRdData,
  output logic [DATA_WIDTH-1:0]     ExWeightSum,
  output logic [DATA_WIDTH-1:0]     InWeightSum,
  output logic [COUNT_WIDTH-1:0]    SpikeCount,
  output logic                      Busy,
  output logic                      Done
);
  typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [SYN_ADDR_WIDTH-1:0] base;
  logic pend_v, pend_ex, hs;
  function automatic logic [DATA_WIDTH-1:0] acc(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
`ifdef SATURATING_ACCUM_EN
    logic [DATA_WIDTH-1:0] s;
    s = a + b;
    if (a[DATA_WIDTH-1] == b[DATA_WIDTH-1] && s[DATA_WIDTH-1] != a[DATA_WIDTH-1])
      s = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return s;
`else
    return a + b;
`endif
  endfunction
  always_comb begin
    SpikeReady   = state == ACCEPT;
    hs           = SpikeValid & SpikeReady;
    WeightRdEn   = hs;
    WeightRdAddr = hs ? base + SpikePreIndex : '0;
    Busy         = state != IDLE;
    Done         = state == DONE;
    state_nxt    = state == IDLE   ? (Start ? ACCEPT : IDLE) :
                   state == ACCEPT ? (hs && SpikeLast ? DRAIN : ACCEPT) :
                   state == DRAIN  ? DONE : IDLE;
  end
  // the weight for a spike accepted in cycle t arrives in t+1 and is summed at the end of t+1
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      base        <= '0;
      pend_v      <= 1'b0;
      pend_ex     <= 1'b0;
      ExWeightSum <= '0;
      InWeightSum <= '0;
      SpikeCount  <= '0;
    end else begin
      state  <= state_nxt;
      pend_v <= hs;
      if (hs) pend_ex <= SpikeExcitatory;
      if (state == IDLE && Start) begin
        base        <= WeightBase;
        ExWeightSum <= '0;
        InWeightSum <= '0;
        SpikeCount  <= '0;
      end else begin
        if (hs) SpikeCount <= SpikeCount + COUNT_WIDTH'(1);
        if (pend_v && pend_ex) ExWeightSum <= acc(ExWeightSum, WeightRdData);
        if (pend_v && !pend_ex) InWeightSum <= acc(InWeightSum, WeightRdData);
      end
    end
  end
endmodule
